// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: takes RV32I instruction fields one per transfer, encodes them
// and writes the words into instruction memory starting at base_addr.
module instr_encoder_loader #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] count,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       cls,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [11:0]      imm,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] wr_cnt
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

    state_t           state;
    logic [31:0]      base_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] wr_cnt_inc;
    logic [31:0]      enc_word;
    logic             enc_legal;
    logic             alu_f3_ok;
    logic             br_f3_ok;

    assign wr_cnt_inc = wr_cnt + CNT_W'(1);

    // ALU ops exclude funct3 010/011; branches allow beq/bne/blt only
    assign alu_f3_ok = (funct3 != 3'b010) && (funct3 != 3'b011);
    assign br_f3_ok  = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b100);

    // Field-to-word encoder with legality check
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b0;
        case (cls)
            3'd0: begin
                enc_word  = {imm, rs1, 3'b010, rd, OP_LOAD};
                enc_legal = (funct3 == 3'b010);
            end
            3'd1: begin
                enc_word  = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
                enc_legal = (funct3 == 3'b010);
            end
            3'd2: begin
                enc_word  = {1'b0, funct7b5, 5'b0, rs2, rs1, funct3, rd, OP_R};
                enc_legal = alu_f3_ok && (!funct7b5 || (funct3 == 3'b000));
            end
            3'd3: begin
                enc_word  = {imm, rs1, funct3, rd, OP_I};
                enc_legal = alu_f3_ok;
            end
            3'd4: begin
                // imm carries offset[12:1]
                enc_word  = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], OP_BRANCH};
                enc_legal = br_f3_ok;
            end
            default: begin
                enc_word  = '0;
                enc_legal = 1'b0;
            end
        endcase
    end

    // Session FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            base_q    <= '0;
            count_q   <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            wr_cnt    <= '0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q  <= base_addr;
                        count_q <= count;
                        wr_cnt  <= '0;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                        if (count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= ACCEPT;
                            in_ready <= 1'b1;
                        end
                    end
                end
                ACCEPT: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (enc_legal) begin
                            state     <= WRITE;
                            mem_we    <= 1'b1;
                            mem_wdata <= enc_word;
                            mem_addr  <= base_q + (32'(wr_cnt) << 2);
                        end else begin
                            err   <= 1'b1;
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    wr_cnt <= wr_cnt_inc;
                    if (wr_cnt_inc < count_q) begin
                        state    <= ACCEPT;
                        in_ready <= 1'b1;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed self-checking bench for instr_encoder_loader.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [7:0]  count;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  cls;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy, done, err;
    logic [7:0]  wr_cnt;

    int checks = 0;
    int errors = 0;

    instr_encoder_loader #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
        .in_valid(in_valid), .in_ready(in_ready), .cls(cls), .funct3(funct3),
        .funct7b5(funct7b5), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic begin_session(input logic [31:0] b, input logic [7:0] n);
        start     = 1'b1;
        base_addr = b;
        count     = n;
        tick();
        start     = 1'b0;
    endtask

    task automatic set_fields(input logic [2:0] c, input logic [2:0] f3, input logic f7,
                              input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                              input logic [11:0] im);
        cls = c; funct3 = f3; funct7b5 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    // One legal transfer: checks the write cycle, then steps past WRITE
    task automatic xfer(input string tag, input logic [31:0] ea, input logic [31:0] ed);
        wait_ready(tag);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_we"},   32'(mem_we), 32'd1);
        chk({tag, "_addr"}, mem_addr, ea);
        chk({tag, "_data"}, mem_wdata, ed);
        tick();
        chk({tag, "_we_off"}, 32'(mem_we), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0; in_valid = 1'b0;
        set_fields(3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 12'd0);
        tick();
        tick();
        chk("rst_busy",     32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_we",       32'(mem_we), 32'd0);
        chk("rst_wr_cnt",   32'(wr_cnt), 32'd0);
        chk("rst_addr",     mem_addr, 32'd0);
        #2 rst_n = 1'b1;
        tick();

        // R-type add then sub, with idle ACCEPT cycle and ignored start mid-session
        begin_session(32'h100, 8'd2);
        chk("s1_ready", 32'(in_ready), 32'd1);
        chk("s1_busy",  32'(busy), 32'd1);
        tick();
        chk("s1_hold_ready", 32'(in_ready), 32'd1);
        chk("s1_hold_we",    32'(mem_we), 32'd0);
        set_fields(3'd2, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0);
        wait_ready("add");
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("add_we",   32'(mem_we), 32'd1);
        chk("add_addr", mem_addr, 32'h100);
        chk("add_data", mem_wdata, 32'h002081B3);
        start = 1'b1; count = 8'd0; base_addr = 32'h900;
        tick();
        start = 1'b0;
        chk("ign_start_ready", 32'(in_ready), 32'd1);
        chk("ign_start_done",  32'(done), 32'd0);
        chk("ign_start_cnt",   32'(wr_cnt), 32'd1);
        set_fields(3'd2, 3'b000, 1'b1, 5'd5, 5'd6, 5'd7, 12'd0);
        xfer("sub", 32'h104, 32'h407302B3);
        chk("s1_done",   32'(done), 32'd1);
        chk("s1_cnt",    32'(wr_cnt), 32'd2);
        tick();
        chk("s1_done_off", 32'(done), 32'd0);
        chk("s1_idle",     32'(busy), 32'd0);
        chk("s1_err",      32'(err), 32'd0);
        chk("s1_cnt_hold", 32'(wr_cnt), 32'd2);

        // lw / sw
        begin_session(32'h0, 8'd2);
        set_fields(3'd0, 3'b010, 1'b0, 5'd2, 5'd0, 5'd0, 12'd8);
        xfer("lw", 32'h0, 32'h00802103);
        set_fields(3'd1, 3'b010, 1'b0, 5'd0, 5'd0, 5'd2, 12'd12);
        xfer("sw", 32'h4, 32'h00202623);
        chk("s2_done", 32'(done), 32'd1);
        tick();

        // Branch and I-ALU (addi x1,x2,-1)
        begin_session(32'h200, 8'd2);
        set_fields(3'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 12'h004);
        xfer("beq", 32'h200, 32'h00208463);
        set_fields(3'd3, 3'b000, 1'b1, 5'd1, 5'd2, 5'd0, 12'hFFF);
        xfer("addi", 32'h204, 32'hFFF10093);
        tick();

        // Illegal branch funct3 as second of three
        begin_session(32'h300, 8'd3);
        set_fields(3'd2, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0);
        xfer("ill_first", 32'h300, 32'h002081B3);
        set_fields(3'd4, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 12'h004);
        wait_ready("ill");
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("ill_we",   32'(mem_we), 32'd0);
        chk("ill_err",  32'(err), 32'd1);
        chk("ill_done", 32'(done), 32'd1);
        chk("ill_cnt",  32'(wr_cnt), 32'd1);
        tick();
        chk("ill_busy_off", 32'(busy), 32'd0);
        chk("ill_err_stick", 32'(err), 32'd1);

        // Wrapping address; err cleared by accepted start
        begin_session(32'hFFFFFFFC, 8'd2);
        chk("wrap_err_clr", 32'(err), 32'd0);
        chk("wrap_cnt_clr", 32'(wr_cnt), 32'd0);
        set_fields(3'd3, 3'b111, 1'b0, 5'd4, 5'd4, 5'd0, 12'h0FF);
        xfer("wrap0", 32'hFFFFFFFC, 32'h0FF27213);
        xfer("wrap1", 32'h00000000, 32'h0FF27213);
        tick();

        // Illegal class aborts with nothing written
        begin_session(32'h400, 8'd1);
        set_fields(3'd6, 3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 12'd0);
        wait_ready("cls6");
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("cls6_we",  32'(mem_we), 32'd0);
        chk("cls6_err", 32'(err), 32'd1);
        chk("cls6_cnt", 32'(wr_cnt), 32'd0);
        tick();

        // Reset during WRITE
        begin_session(32'h0, 8'd2);
        set_fields(3'd2, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0);
        wait_ready("rstw");
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("rstw_we_before", 32'(mem_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstw_we",   32'(mem_we), 32'd0);
        chk("rstw_busy", 32'(busy), 32'd0);
        chk("rstw_cnt",  32'(wr_cnt), 32'd0);
        #1 rst_n = 1'b1;
        tick();
        chk("rstw_idle", 32'(busy), 32'd0);
        chk("rstw_no_we", 32'(mem_we), 32'd0);

        // Zero-count session
        begin_session(32'h500, 8'd0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_we",   32'(mem_we), 32'd0);
        chk("zero_busy", 32'(busy), 32'd1);
        tick();
        chk("zero_done_off", 32'(done), 32'd0);
        chk("zero_busy_off", 32'(busy), 32'd0);
        chk("zero_cnt",      32'(wr_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
